// File: rtl/hack_mem_pkg.sv
// Shared types for the Hack RAM front end: data word, port id, default burst cap.
// No logic here; purely declarations.
package hack_mem_pkg;
    typedef logic [15:0] word_t;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_id_t;

    localparam int DEFAULT_MAX_BURST = 4;
endpackage

// File: rtl/ram_arbiter_if.sv
// Bundles both requester ports and the RAM pins of the arbiter.
// slave = arbiter side, master = requesters + RAM side.
interface ram_arbiter_if #(
    parameter int WIDTH = 3
);
    import hack_mem_pkg::*;

    logic             p0_req;
    logic             p0_we;
    logic [WIDTH-1:0] p0_addr;
    word_t            p0_wdata;
    logic             p0_gnt;
    word_t            p0_rdata;
    logic             p0_rvalid;

    logic             p1_req;
    logic             p1_we;
    logic [WIDTH-1:0] p1_addr;
    word_t            p1_wdata;
    logic             p1_gnt;
    word_t            p1_rdata;
    logic             p1_rvalid;

    logic [WIDTH-1:0] ram_address;
    word_t            ram_in;
    logic             ram_load;
    word_t            ram_out;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        input  ram_out,
        output p0_gnt, p0_rdata, p0_rvalid,
        output p1_gnt, p1_rdata, p1_rvalid,
        output ram_address, ram_in, ram_load
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        output ram_out,
        input  p0_gnt, p0_rdata, p0_rvalid,
        input  p1_gnt, p1_rdata, p1_rvalid,
        input  ram_address, ram_in, ram_load
    );
endinterface

// File: rtl/rr_pick.sv
// Round-robin pick between two requesters with a burst cap on the current owner.
// Purely combinational; a losing requester just keeps req asserted.
module rr_pick
    import hack_mem_pkg::*;
(
    input  logic [1:0] req_i,
    input  port_id_t   owner_i,
    input  logic       busy_i,
    input  logic       cnt_lt_max_i,
    output logic       grant_valid_o,
    output port_id_t   sel_o
);
    port_id_t other;
    assign other = port_id_t'(~owner_i);

    always_comb begin
        grant_valid_o = 1'b1;
        sel_o         = owner_i;
        // Owner keeps the RAM while bursting, unless capped and the other side waits.
        if (busy_i && req_i[owner_i] && (cnt_lt_max_i || !req_i[other])) begin
            sel_o = owner_i;
        end else if (req_i[other]) begin
            sel_o = other;
        end else if (req_i[owner_i]) begin
            sel_o = owner_i;
        end else begin
            grant_valid_o = 1'b0;
        end
    end
endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port Hack RAM between two requesters, round-robin with a burst cap.
// Grant is same-cycle; read data returns one cycle later with a one-cycle rvalid.
module ram_arbiter
    import hack_mem_pkg::*;
#(
    parameter int SIZE      = 8,
    parameter int WIDTH     = $clog2(SIZE),
    parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
    input logic          clk,
    input logic          reset,
    ram_arbiter_if.slave bus
);
    localparam int             CW   = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0]  MAXC = CW'(MAX_BURST);

    port_id_t      owner_q, owner_d;
    logic          busy_q, busy_d;
    logic [CW-1:0] cnt_q, cnt_d;
    word_t         p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;
    logic          p0_rvalid_q, p0_rvalid_d, p1_rvalid_q, p1_rvalid_d;

    logic             pick_vld, gnt_vld;
    port_id_t         sel;
    logic             sel_we;
    logic [WIDTH-1:0] sel_addr;
    word_t            sel_wdata;

    rr_pick u_pick (
        .req_i         ({bus.p1_req, bus.p0_req}),
        .owner_i       (owner_q),
        .busy_i        (busy_q),
        .cnt_lt_max_i  (cnt_q < MAXC),
        .grant_valid_o (pick_vld),
        .sel_o         (sel)
    );

    // Nothing touches the RAM while reset is held.
    assign gnt_vld   = pick_vld && !reset;
    assign sel_we    = (sel == PORT1) ? bus.p1_we    : bus.p0_we;
    assign sel_addr  = (sel == PORT1) ? bus.p1_addr  : bus.p0_addr;
    assign sel_wdata = (sel == PORT1) ? bus.p1_wdata : bus.p0_wdata;

    assign bus.p0_gnt      = gnt_vld && (sel == PORT0);
    assign bus.p1_gnt      = gnt_vld && (sel == PORT1);
    assign bus.ram_address = gnt_vld ? sel_addr  : '0;
    assign bus.ram_in      = gnt_vld ? sel_wdata : '0;
    assign bus.ram_load    = gnt_vld && sel_we;

    assign bus.p0_rdata  = p0_rdata_q;
    assign bus.p0_rvalid = p0_rvalid_q;
    assign bus.p1_rdata  = p1_rdata_q;
    assign bus.p1_rvalid = p1_rvalid_q;

    always_comb begin
        owner_d     = owner_q;
        busy_d      = 1'b0;
        cnt_d       = '0;
        p0_rdata_d  = p0_rdata_q;
        p1_rdata_d  = p1_rdata_q;
        p0_rvalid_d = 1'b0;
        p1_rvalid_d = 1'b0;
        if (gnt_vld) begin
            busy_d  = 1'b1;
            owner_d = sel;
            if (busy_q && (sel == owner_q)) begin
                cnt_d = (cnt_q == MAXC) ? cnt_q : cnt_q + 1'b1;
            end else begin
                cnt_d = CW'(1);
            end
            if (!sel_we) begin
                if (sel == PORT0) begin
                    p0_rdata_d  = bus.ram_out;
                    p0_rvalid_d = 1'b1;
                end else begin
                    p1_rdata_d  = bus.ram_out;
                    p1_rvalid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q     <= PORT1;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
        end else begin
            owner_q     <= owner_d;
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
            p0_rdata_q  <= p0_rdata_d;
            p1_rdata_q  <= p1_rdata_d;
            p0_rvalid_q <= p0_rvalid_d;
            p1_rvalid_q <= p1_rvalid_d;
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter (MAX_BURST=2) with a behavioural Hack RAM beside it.
module tb_ram_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    ram_arbiter_if #(.WIDTH(3)) bus ();

    ram_arbiter #(.SIZE(8), .WIDTH(3), .MAX_BURST(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Hack RAM: combinational read, write on rising edge, no reset.
    logic [15:0] mem [8] = '{default: 16'd0};
    assign bus.ram_out = mem[bus.ram_address];
    always @(posedge clk) begin
        if (bus.ram_load) mem[bus.ram_address] <= bus.ram_in;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_p0(input logic req, input logic we, input logic [2:0] addr, input logic [15:0] wd);
        bus.p0_req = req; bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wd;
    endtask

    task automatic set_p1(input logic req, input logic we, input logic [2:0] addr, input logic [15:0] wd);
        bus.p1_req = req; bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wd;
    endtask

    task automatic idle();
        set_p0(1'b0, 1'b0, 3'd0, 16'd0);
        set_p1(1'b0, 1'b0, 3'd0, 16'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        tick();
        reset = 1'b0;
    endtask

    bit exp_p0 [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        // Reset: a pending write must not reach the RAM.
        reset = 1'b1;
        idle();
        set_p0(1'b1, 1'b1, 3'd1, 16'd5);
        tick();
        tick();
        chk("rst_p0_gnt", bus.p0_gnt, 0);
        chk("rst_ram_load", bus.ram_load, 0);
        chk("rst_p0_rvalid", bus.p0_rvalid, 0);
        chk("rst_p1_rvalid", bus.p1_rvalid, 0);
        chk("rst_p0_rdata", bus.p0_rdata, 0);
        chk("rst_p1_rdata", bus.p1_rdata, 0);

        // p0 write then p1 read of the same address.
        reset = 1'b0;
        set_p0(1'b1, 1'b1, 3'd1, 16'd11111);
        #1;
        chk("t1_p0_gnt", bus.p0_gnt, 1);
        chk("t1_p1_gnt", bus.p1_gnt, 0);
        chk("t1_ram_load", bus.ram_load, 1);
        chk("t1_ram_addr", bus.ram_address, 1);
        chk("t1_ram_in", bus.ram_in, 11111);
        tick();
        set_p0(1'b0, 1'b0, 3'd0, 16'd0);
        set_p1(1'b1, 1'b0, 3'd1, 16'd0);
        #1;
        chk("t1_p1_gnt", bus.p1_gnt, 1);
        chk("t1_rd_load", bus.ram_load, 0);
        chk("t1_wr_no_rvalid", bus.p0_rvalid, 0);
        tick();
        idle();
        #1;
        chk("t1_p1_rvalid", bus.p1_rvalid, 1);
        chk("t1_p1_rdata", bus.p1_rdata, 11111);
        tick();
        chk("t1_p1_rvalid_pulse", bus.p1_rvalid, 0);
        chk("t1_p1_rdata_hold", bus.p1_rdata, 11111);

        // Simultaneous reads after idle: p0 first, then p1.
        do_reset();
        set_p1(1'b1, 1'b1, 3'd3, 16'd3333);
        #1;
        chk("t2_pre_p1_gnt", bus.p1_gnt, 1);
        tick();
        idle();
        tick();
        set_p0(1'b1, 1'b0, 3'd0, 16'd0);
        set_p1(1'b1, 1'b0, 3'd3, 16'd0);
        #1;
        chk("t2_c0_p0_gnt", bus.p0_gnt, 1);
        chk("t2_c0_p1_gnt", bus.p1_gnt, 0);
        tick();
        set_p0(1'b0, 1'b0, 3'd0, 16'd0);
        #1;
        chk("t2_c1_p1_gnt", bus.p1_gnt, 1);
        chk("t2_p0_rvalid", bus.p0_rvalid, 1);
        chk("t2_p0_rdata", bus.p0_rdata, 0);
        tick();
        idle();
        #1;
        chk("t2_p1_rvalid", bus.p1_rvalid, 1);
        chk("t2_p1_rdata", bus.p1_rdata, 3333);
        chk("t2_p0_rvalid_off", bus.p0_rvalid, 0);
        tick();

        // Burst cap of 2: p0 from cycle 0, p1 from cycle 1.
        do_reset();
        for (int c = 0; c < 6; c++) begin
            set_p0(1'b1, 1'b0, 3'd0, 16'd0);
            if (c >= 1) set_p1(1'b1, 1'b0, 3'd3, 16'd0);
            #1;
            chk($sformatf("t3_c%0d_p0_gnt", c), bus.p0_gnt, 32'(exp_p0[c]));
            chk($sformatf("t3_c%0d_p1_gnt", c), bus.p1_gnt, 32'(!exp_p0[c]));
            tick();
        end
        idle();
        tick();

        // p0 streams writes alone, then reads everything back.
        for (int i = 0; i < 8; i++) begin
            set_p0(1'b1, 1'b1, 3'(i), 16'(1000 + i));
            #1;
            chk($sformatf("t4_wr%0d_gnt", i), bus.p0_gnt, 1);
            tick();
        end
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) set_p0(1'b1, 1'b0, 3'(i), 16'd0);
            else       set_p0(1'b0, 1'b0, 3'd0, 16'd0);
            #1;
            if (i < 8) chk($sformatf("t4_rd%0d_gnt", i), bus.p0_gnt, 1);
            if (i > 0) begin
                chk($sformatf("t4_rd%0d_rvalid", i - 1), bus.p0_rvalid, 1);
                chk($sformatf("t4_rd%0d_rdata", i - 1), bus.p0_rdata, 32'(1000 + i - 1));
            end
            tick();
        end

        // Same-address race with owner=1: p0 write wins, p1 read sees new value.
        do_reset();
        set_p0(1'b1, 1'b1, 3'd7, 16'd7777);
        set_p1(1'b1, 1'b0, 3'd7, 16'd0);
        #1;
        chk("t5_p0_gnt", bus.p0_gnt, 1);
        chk("t5_p1_gnt", bus.p1_gnt, 0);
        chk("t5_ram_load", bus.ram_load, 1);
        chk("t5_ram_addr", bus.ram_address, 7);
        tick();
        set_p0(1'b0, 1'b0, 3'd0, 16'd0);
        #1;
        chk("t5_p1_gnt", bus.p1_gnt, 1);
        chk("t5_mem7", mem[7], 7777);
        tick();
        idle();
        #1;
        chk("t5_p1_rvalid", bus.p1_rvalid, 1);
        chk("t5_p1_rdata", bus.p1_rdata, 7777);
        tick();

        // Reset during a p1 read grant.
        set_p1(1'b1, 1'b0, 3'd5, 16'd0);
        #1;
        chk("t6_p1_gnt_pre", bus.p1_gnt, 1);
        reset = 1'b1;
        #1;
        chk("t6_p1_gnt_in_rst", bus.p1_gnt, 0);
        tick();
        reset = 1'b0;
        idle();
        #1;
        chk("t6_p1_rvalid", bus.p1_rvalid, 0);
        chk("t6_p1_rdata_rst", bus.p1_rdata, 0);
        set_p0(1'b1, 1'b0, 3'd5, 16'd0);
        set_p1(1'b1, 1'b0, 3'd2, 16'd0);
        #1;
        chk("t6_p0_wins", bus.p0_gnt, 1);
        chk("t6_p1_loses", bus.p1_gnt, 0);
        tick();
        set_p0(1'b0, 1'b0, 3'd0, 16'd0);
        #1;
        chk("t6_p0_rvalid", bus.p0_rvalid, 1);
        chk("t6_p0_rdata", bus.p0_rdata, 1005);
        tick();
        idle();
        #1;
        chk("t6_p1_rvalid_after", bus.p1_rvalid, 1);
        chk("t6_p1_rdata_after", bus.p1_rdata, 1002);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-port front end that shares one single-port Hack RAM instance (16-bit words, combinational read, write on rising clk edge) between two requesters, e.g. the CPU data port and a DMA/screen-refresh engine.
- Grants at most one requester per cycle.
- Uses round-robin priority with a bounded burst length so a streaming requester cannot starve the other.
- Drives the RAM's in/address/load pins; registers read data back to the winning requester.

Parameters:
- SIZE, 8, number of RAM words; must match the attached RAM instance.
- WIDTH, $clog2(SIZE), address width.
- MAX_BURST, 4, max consecutive grants to one requester while the other is waiting (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- p0_req  in  1  port 0 access request, held until granted.
- p0_we  in  1  port 0: 1 = write, 0 = read.
- p0_addr  in  WIDTH  port 0 word address.
- p0_wdata  in  16  port 0 write data.
- p0_gnt  out  1  port 0 access performed this cycle (combinational).
- p0_rdata  out  16  port 0 registered read data.
- p0_rvalid  out  1  p0_rdata valid (one-cycle pulse).
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rdata, p1_rvalid  same as port 0, for port 1.
- ram_address  out  WIDTH  to RAM address.
- ram_in  out  16  to RAM in.
- ram_load  out  1  to RAM load.
- ram_out  in  16  from RAM out.

Behaviour:
- State registers: owner (last-granted port, 0/1), busy (a grant occurred last cycle), cnt (consecutive grants to owner, width $clog2(MAX_BURST+1), saturating at MAX_BURST).
- Reset values: owner=1 (port 0 wins the first contention), busy=0, cnt=0, p*_rvalid=0, p*_rdata=0.
- ram_load is forced 0 while reset is high; p*_gnt is also 0 during reset.
- Combinational selection, each cycle:
  - if busy && req[owner] && (cnt<MAX_BURST || !req[~owner]) -> sel=owner
  - else if req[~owner] -> sel=~owner
  - else if req[owner] -> sel=owner
  - else no grant.
- Grant outputs: p{sel}_gnt=1; the other port's gnt=0.
- RAM drive:
  - When granted: ram_address=p{sel}_addr, ram_in=p{sel}_wdata, ram_load=p{sel}_we.
  - With no grant: ram_address=0, ram_in=0, ram_load=0.
- On clk edge with a grant:
  - busy<=1, owner<=sel.
  - cnt<=(busy && sel==owner) ? sat(cnt+1) : 1.
- On clk edge without a grant: busy<=0, cnt<=0, owner unchanged.
- Write latency: data is in RAM at the edge ending the grant cycle. There is no rvalid for writes.
- Read latency: on the edge ending a read grant, p{sel}_rdata<=ram_out and p{sel}_rvalid<=1 for exactly one cycle.
- rvalid is 0 in all other cycles. rdata holds its last value.
- Write followed by read of the same address (any port, consecutive grants) returns the new value.
- Both ports targeting the same address in one cycle: only the selected access happens; the loser retries with req held.
- A requester dropping req mid-burst releases immediately. With no requests, busy clears and the next grant goes to ~owner.
- Reset mid-burst: state returns to reset values and any pending rvalid is cleared. RAM contents are untouched (the RAM has no reset).

Decomposition:
- Package hack_mem_pkg:
  - word_t (logic [15:0])
  - port_id_t (1-bit enum PORT0/PORT1)
  - DEFAULT_MAX_BURST constant
- Sub-module rr_pick (combinational): inputs req[1:0], owner, busy, cnt_lt_max; outputs grant_valid and sel. Keeps the priority rule testable in isolation.
- The arbiter holds only registers and muxing. The RAM is instantiated beside it, in the parent.

Test Plan:
- Reset, then p0 write addr1=11111. Expect p0_gnt=1, ram_load=1 that cycle. Next cycle p1 read addr1: p1_gnt=1, then one cycle later p1_rvalid=1 and p1_rdata=11111.
- Idle after reset, both ports request in the same cycle (p0 read addr0, p1 read addr3 holding 3333). Expect:
  - cycle 0: p0 granted
  - cycle 1: p1 granted
  - p0_rdata=0, then p1_rdata=3333, each with a one-cycle rvalid.
- MAX_BURST=2, p0 requests continuously from cycle 0, p1 continuously from cycle 1. Expected grant sequence cycles 0..5 = p0,p0,p1,p1,p0,p0.
- p0 alone streams writes addr0..7 with values 1000+i for 8 cycles. Expect p0_gnt=1 every cycle (no starvation stall when p1 idle). Then readback of all 8 addresses returns 1000+i.
- Same-address race: p0 writes addr7=7777 while p1 reads addr7 in the same cycle, with owner=1. Expect p0 wins and writes. Next cycle p1 is granted and returns 7777.
- Assert reset during a p1 read grant. Expect p1_rvalid=0 the next cycle, busy cleared, and the first post-reset contention won by p0. RAM still holds previously written values.
